// File: rtl/vmem_port_arbiter_if.sv
// Shared vector data-memory port bundle: CPU M-stage side, DMA side,
// the physical memory port and the arbiter performance counters.
// slave  : arbiter view (takes requests, drives the memory port)
// master : environment view (pipeline, DMA engine and memory)
interface vmem_port_arbiter_if #(
  parameter int unsigned DW = 128,
  parameter int unsigned AW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_q;

  logic [31:0]   perf_stall_cnt;
  logic [31:0]   perf_dma_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_q,
    output perf_stall_cnt, perf_dma_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_q,
    input  perf_stall_cnt, perf_dma_cnt
  );
endinterface

// File: rtl/vmem_port_arbiter.sv
// vmem_port_arbiter: shares the single vector data-memory port between the
// pipeline (priority) and the audio DMA engine, with a bounded-starvation
// counter that forces DMA through after MAX_WAIT consecutive denials.
// Read data is routed back through a RD_LAT-deep (valid, owner) tag pipe.
// Optional macro ARB_PERF_CNT_EN builds the stall / DMA-grant counters;
// without it both counter outputs are tied to zero.
module vmem_port_arbiter #(
  parameter int unsigned DW       = 128,
  parameter int unsigned AW       = 16,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  vmem_port_arbiter_if.slave bus
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  owner_e            owner;
  logic [WW-1:0]     wait_cnt;
  logic [WW-1:0]     wait_nxt;
  logic              rd_grant;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_dma;
  logic              ret_v;
  logic              ret_cpu;
  logic              ret_dma;
  logic [DW-1:0]     cpu_hold;
  logic [DW-1:0]     dma_hold;

  // Per-cycle grant decision and next starvation count; nothing granted in reset
  always_comb begin
    owner    = OWN_NONE;
    wait_nxt = '0;
    if (reset) begin
      if (bus.cpu_req && bus.dma_req) begin
        if (wait_cnt >= WW'(MAX_WAIT)) begin
          owner = OWN_DMA;
        end else begin
          owner    = OWN_CPU;
          wait_nxt = wait_cnt + WW'(1);
        end
      end else if (bus.cpu_req) begin
        owner = OWN_CPU;
      end else if (bus.dma_req) begin
        owner = OWN_DMA;
      end
    end
  end

  // Memory port mux driven straight from the granted requester
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (owner)
      OWN_CPU: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.cpu_we;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
      end
      OWN_DMA: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.dma_we;
        bus.mem_addr  = bus.dma_addr;
        bus.mem_wdata = bus.dma_wdata;
      end
      default: ;
    endcase
  end

  assign bus.dma_gnt   = (owner == OWN_DMA);
  assign bus.cpu_stall = bus.cpu_req && (owner == OWN_DMA);
  assign rd_grant      = (owner != OWN_NONE) && !bus.mem_we;

  // Starvation counter and read tag pipe; reset discards in-flight reads
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
      tag_v    <= '0;
      tag_dma  <= '0;
    end else begin
      wait_cnt   <= wait_nxt;
      tag_v[0]   <= rd_grant;
      tag_dma[0] <= (owner == OWN_DMA);
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_dma[i] <= tag_dma[i-1];
      end
    end
  end

  assign ret_v   = reset && tag_v[RD_LAT-1];
  assign ret_cpu = ret_v && !tag_dma[RD_LAT-1];
  assign ret_dma = ret_v && tag_dma[RD_LAT-1];

  // Hold each owner's last returned word between returns
  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_hold <= '0;
      dma_hold <= '0;
    end else begin
      if (ret_cpu) cpu_hold <= bus.mem_q;
      if (ret_dma) dma_hold <= bus.mem_q;
    end
  end

  assign bus.cpu_rvalid = ret_cpu;
  assign bus.dma_rvalid = ret_dma;
  assign bus.cpu_rdata  = ret_cpu ? bus.mem_q : cpu_hold;
  assign bus.dma_rdata  = ret_dma ? bus.mem_q : dma_hold;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] dma_cnt;

  // Free-running wrap-around counters of stalled CPU cycles and DMA grants
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      dma_cnt   <= '0;
    end else begin
      if (bus.cpu_stall) stall_cnt <= stall_cnt + 32'd1;
      if (bus.dma_gnt)   dma_cnt   <= dma_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = stall_cnt;
  assign bus.perf_dma_cnt   = dma_cnt;
`else
  assign bus.perf_stall_cnt = '0;
  assign bus.perf_dma_cnt   = '0;
`endif

endmodule

// File: tb/tb_vmem_port_arbiter.sv
// Bench for vmem_port_arbiter: two instances (RD_LAT=1 and RD_LAT=2) share the
// same stimulus; a transaction-level model (denial streak + return schedule
// indexed by cycle) predicts every output each cycle.
module tb_vmem_port_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int SCHED_N  = 2048;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0]  cpu_addr, dma_addr;
  logic [127:0] cpu_wdata, dma_wdata, mem_q;

  always #5 clk = ~clk;

  vmem_port_arbiter_if #(.DW(128), .AW(16)) if1 ();
  vmem_port_arbiter_if #(.DW(128), .AW(16)) if2 ();

  assign if1.cpu_req = cpu_req;   assign if2.cpu_req = cpu_req;
  assign if1.cpu_we = cpu_we;     assign if2.cpu_we = cpu_we;
  assign if1.cpu_addr = cpu_addr; assign if2.cpu_addr = cpu_addr;
  assign if1.cpu_wdata = cpu_wdata; assign if2.cpu_wdata = cpu_wdata;
  assign if1.dma_req = dma_req;   assign if2.dma_req = dma_req;
  assign if1.dma_we = dma_we;     assign if2.dma_we = dma_we;
  assign if1.dma_addr = dma_addr; assign if2.dma_addr = dma_addr;
  assign if1.dma_wdata = dma_wdata; assign if2.dma_wdata = dma_wdata;
  assign if1.mem_q = mem_q;       assign if2.mem_q = mem_q;

  vmem_port_arbiter #(.DW(128), .AW(16), .RD_LAT(1), .MAX_WAIT(MAX_WAIT)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));
  vmem_port_arbiter #(.DW(128), .AW(16), .RD_LAT(2), .MAX_WAIT(MAX_WAIT)) dut2 (
    .clk(clk), .reset(reset), .bus(if2.slave));

  // Reference model state
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           streak = 0;              // consecutive cycles DMA was denied
  int           lat [2] = '{1, 2};
  int           sched [2][SCHED_N];      // owner returning at a cycle: 0 none, 1 cpu, 2 dma
  logic [127:0] hold [2][2];
  bit           known [2][2];
  logic [31:0]  exp_stall_cnt = 0;
  logic [31:0]  exp_dma_cnt = 0;
  int           own;                     // this cycle's expected owner
  int           gnt_seen;
  int           rv_seen;
  bit           dma_pending;
  bit           cpu_pending;

  task automatic chk(input string tag, input int d, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[lat%0d] cyc=%0d observed=%0h expected=%0h", tag, lat[d], cyc, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic stall, input logic gnt, input logic en,
                           input logic we, input logic [15:0] addr, input logic [127:0] wdata,
                           input logic crv, input logic [127:0] crd, input logic drv,
                           input logic [127:0] drd, input logic [31:0] psc, input logic [31:0] pdc);
    int rv;
    logic [31:0] e_psc, e_pdc;
    rv = reset ? sched[d][cyc] : 0;
    chk("cpu_stall", d, stall, cpu_req && own == 2);
    chk("dma_gnt", d, gnt, own == 2);
    chk("mem_en", d, en, own != 0);
    chk("mem_we", d, we, own == 1 ? cpu_we : own == 2 ? dma_we : 1'b0);
    if (own != 0) begin
      chk("mem_addr", d, addr, own == 1 ? cpu_addr : dma_addr);
      chk("mem_wdata", d, wdata, own == 1 ? cpu_wdata : dma_wdata);
    end
    chk("cpu_rvalid", d, crv, rv == 1);
    chk("dma_rvalid", d, drv, rv == 2);
    if (rv == 1) chk("cpu_rdata", d, crd, mem_q);
    else if (known[d][0]) chk("cpu_rdata_hold", d, crd, hold[d][0]);
    if (rv == 2) chk("dma_rdata", d, drd, mem_q);
    else if (known[d][1]) chk("dma_rdata_hold", d, drd, hold[d][1]);
`ifdef ARB_PERF_CNT_EN
    e_psc = exp_stall_cnt;
    e_pdc = exp_dma_cnt;
`else
    e_psc = 0;
    e_pdc = 0;
`endif
    chk("perf_stall_cnt", d, psc, e_psc);
    chk("perf_dma_cnt", d, pdc, e_pdc);
  endtask

  // One clock cycle: inputs already applied; check mid-cycle, then advance model
  task automatic tick();
    logic rd;
    mem_q = {$urandom, $urandom, $urandom, $urandom};
    own = 0;
    if (reset) begin
      if (cpu_req && dma_req) own = (streak >= MAX_WAIT) ? 2 : 1;
      else if (cpu_req) own = 1;
      else if (dma_req) own = 2;
    end
    @(negedge clk);
    check_dut(0, if1.cpu_stall, if1.dma_gnt, if1.mem_en, if1.mem_we, if1.mem_addr,
              if1.mem_wdata, if1.cpu_rvalid, if1.cpu_rdata, if1.dma_rvalid, if1.dma_rdata,
              if1.perf_stall_cnt, if1.perf_dma_cnt);
    check_dut(1, if2.cpu_stall, if2.dma_gnt, if2.mem_en, if2.mem_we, if2.mem_addr,
              if2.mem_wdata, if2.cpu_rvalid, if2.cpu_rdata, if2.dma_rvalid, if2.dma_rdata,
              if2.perf_stall_cnt, if2.perf_dma_cnt);
    if (if1.dma_gnt) gnt_seen++;
    if (if1.cpu_rvalid || if1.dma_rvalid || if2.cpu_rvalid || if2.dma_rvalid) rv_seen++;
    rd = (own == 1) ? !cpu_we : (own == 2) ? !dma_we : 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        for (int k = cyc + 1; k <= cyc + 2 && k < SCHED_N; k++) sched[d][k] = 0;
        known[d][0] = 0;
        known[d][1] = 0;
      end else begin
        if (sched[d][cyc] != 0) begin
          hold[d][sched[d][cyc]-1]  = mem_q;
          known[d][sched[d][cyc]-1] = 1;
        end
        if (rd && cyc + lat[d] < SCHED_N) sched[d][cyc + lat[d]] = own;
      end
    end
    if (!reset) begin
      streak = 0;
      exp_stall_cnt = 0;
      exp_dma_cnt = 0;
    end else begin
      streak = (cpu_req && dma_req && own == 1) ? streak + 1 : 0;
      if (cpu_req && own == 2) exp_stall_cnt = exp_stall_cnt + 1;
      if (own == 2) exp_dma_cnt = exp_dma_cnt + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [15:0] a, input logic [127:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [15:0] a, input logic [127:0] wd);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = wd;
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < SCHED_N; k++) sched[d][k] = 0;
    reset = 1'b0;
    set_cpu(0, 0, '0, '0);
    set_dma(0, 0, '0, '0);
    mem_q = '0;
    @(posedge clk);
    #1;

    // Reset held with requests active: everything quiet
    set_cpu(1, 0, 16'h0001, '0);
    set_dma(1, 1, 16'h0002, '1);
    repeat (3) tick();
    reset = 1'b1;
    set_cpu(0, 0, '0, '0);
    set_dma(0, 0, '0, '0);
    tick();

    // CPU-only load at 0x0010
    set_cpu(1, 0, 16'h0010, '0);
    tick();
    set_cpu(0, 0, '0, '0);
    repeat (3) tick();

    // Both requesting continuously: 4 CPU grants then one forced DMA grant
    gnt_seen = 0;
    set_cpu(1, 0, 16'h0100, '0);
    set_dma(1, 0, 16'h0200, '0);
    repeat (15) tick();
    chk("starve_4to1_grants", 0, 128'(gnt_seen), 128'd3);
    set_cpu(0, 0, '0, '0);
    set_dma(0, 0, '0, '0);
    repeat (2) tick();

    // DMA read then CPU read on the next cycle
    set_dma(1, 0, 16'h0300, '0);
    tick();
    set_dma(0, 0, '0, '0);
    set_cpu(1, 0, 16'h0301, '0);
    tick();
    set_cpu(0, 0, '0, '0);
    repeat (4) tick();

    // DMA block write with CPU idle
    set_dma(1, 1, 16'h0400, {16{8'hA5}});
    tick();
    set_dma(0, 0, '0, '0);
    repeat (3) tick();

    // Reset one cycle after a granted read: no return may appear
    set_cpu(1, 0, 16'h0500, '0);
    tick();
    set_cpu(0, 0, '0, '0);
    rv_seen = 0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("no_rvalid_after_reset", 0, 128'(rv_seen), 128'd0);

    // Ten starvation-forced DMA grants from a fresh reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_cpu(1, 1, 16'h0600, 128'h1);
    set_dma(1, 1, 16'h0700, 128'h2);
    repeat (50) tick();
    set_cpu(0, 0, '0, '0);
    set_dma(0, 0, '0, '0);
    tick();
`ifdef ARB_PERF_CNT_EN
    chk("perf_dma_10", 0, 128'(if1.perf_dma_cnt), 128'd10);
    chk("perf_stall_10", 0, 128'(if1.perf_stall_cnt), 128'd10);
`else
    chk("perf_dma_off", 0, 128'(if1.perf_dma_cnt), 128'd0);
    chk("perf_stall_off", 0, 128'(if1.perf_stall_cnt), 128'd0);
`endif

    // Randomised traffic: DMA holds its request until granted, stalled CPU holds too
    dma_pending = 0;
    cpu_pending = 0;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      if (!cpu_pending)
        set_cpu(1'($urandom_range(0, 99) < 60), 1'($urandom), 16'($urandom),
                {$urandom, $urandom, $urandom, $urandom});
      if (!dma_pending)
        set_dma(1'($urandom_range(0, 99) < 50), 1'($urandom), 16'($urandom),
                {$urandom, $urandom, $urandom, $urandom});
      tick();
      cpu_pending = reset && cpu_req && own == 2;
      dma_pending = reset && dma_req && own != 2;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
